// File: rtl/dsp_rf_pkg.sv
// Shared types and constants for the DSP extension-register sequencer.
// Defines the FSM state encoding, the register indices and the stall counter helper.
package dsp_rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REG_SRC_A = 16;
    localparam int REG_SRC_B = 17;
    localparam int REG_ACC   = 18;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 16;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        logic [STALL_W-1:0] r;
        if (v == {STALL_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STALL_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_rf_sequencer_if.sv
// Bundle of start/count, core writeback, register taps and register-file write port.
// master drives commands and taps; slave is the sequencer.
interface dsp_rf_sequencer_if
    import dsp_rf_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic                start;
    logic [CNT_W-1:0]    count;
    logic                core_we;
    logic [ADDR_W-1:0]   core_rd_addr;
    logic [DATA_W-1:0]   core_rd_data;
    logic [DATA_W-1:0]   r16_in;
    logic [DATA_W-1:0]   r17_in;
    logic [DATA_W-1:0]   r18_in;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_rd_addr;
    logic [DATA_W-1:0]   rf_rd_data;
    logic                busy;
    logic                done;
    logic [STALL_W-1:0]  stall_cnt;

    modport master (
        output start, count, core_we, core_rd_addr, core_rd_data,
               r16_in, r17_in, r18_in,
        input  rf_we, rf_rd_addr, rf_rd_data, busy, done, stall_cnt
    );

    modport slave (
        input  start, count, core_we, core_rd_addr, core_rd_data,
               r16_in, r17_in, r18_in,
        output rf_we, rf_rd_addr, rf_rd_data, busy, done, stall_cnt
    );

endinterface

// File: rtl/dsp_mac32.sv
// Combinational low-word multiply-accumulate: o_y = i_c + i_a * i_b (mod 2^32).
// Kept standalone so a pipelined version can drop in later.
module dsp_mac32
    import dsp_rf_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_y
);

    // 32-bit context keeps only the low product word, identical for signed operands.
    assign o_y = i_c + (i_a * i_b);

endmodule

// File: rtl/dsp_rf_sequencer.sv
// Runs N iterations of ACC <= ACC + SRC_A*SRC_B through the register file's single
// write port, yielding the port to the core writeback stage with strict priority.
module dsp_rf_sequencer
    import dsp_rf_pkg::*;
#(
    parameter int SRC_A = REG_SRC_A,
    parameter int SRC_B = REG_SRC_B,
    parameter int ACC   = REG_ACC,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dsp_rf_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] A_SRC_A = ADDR_W'(SRC_A);
    localparam logic [ADDR_W-1:0] A_SRC_B = ADDR_W'(SRC_B);
    localparam logic [ADDR_W-1:0] A_ACC   = ADDR_W'(ACC);
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    w_remaining_nxt;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   w_result_nxt;
    logic [STALL_W-1:0]  r_stall;
    logic [STALL_W-1:0]  w_stall_nxt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   w_mac;
    logic                w_hazard;

    dsp_mac32 u_mac (
        .i_a (bus.r16_in),
        .i_b (bus.r17_in),
        .i_c (bus.r18_in),
        .o_y (w_mac)
    );

    // A core write to any operand register makes the taps stale for this cycle.
    assign w_hazard = bus.core_we &&
                      ((bus.core_rd_addr == A_SRC_A) ||
                       (bus.core_rd_addr == A_SRC_B) ||
                       (bus.core_rd_addr == A_ACC));

    // State, iteration counter, latched result and stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= {CNT_W{1'b0}};
            r_result    <= {DATA_W{1'b0}};
            r_stall     <= {STALL_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_result    <= w_result_nxt;
            r_stall     <= w_stall_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    // Next-state logic and register updates for the iteration loop.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_result_nxt    = r_result;
        w_stall_nxt     = r_stall;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count == {CNT_W{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt     = CALC;
                        w_remaining_nxt = bus.count;
                        w_stall_nxt     = {STALL_W{1'b0}};
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_hazard) begin
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt  = WRITE;
                    w_result_nxt = w_mac;
                end
            end
            WRITE: begin
                if (w_hazard) begin
                    w_state_nxt = CALC;
                    w_stall_nxt = sat_inc(r_stall);
                end else if (bus.core_we) begin
                    w_state_nxt = WRITE;
                    w_stall_nxt = sat_inc(r_stall);
                end else begin
                    w_remaining_nxt = r_remaining - CNT_ONE;
                    if (r_remaining == CNT_ONE) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write-port mux: core always wins; the sequencer drives only in WRITE.
    always_comb begin
        bus.rf_we      = 1'b0;
        bus.rf_rd_addr = {ADDR_W{1'b0}};
        bus.rf_rd_data = {DATA_W{1'b0}};
        if (bus.core_we) begin
            bus.rf_we      = 1'b1;
            bus.rf_rd_addr = bus.core_rd_addr;
            bus.rf_rd_data = bus.core_rd_data;
        end else if (r_state == WRITE) begin
            bus.rf_we      = 1'b1;
            bus.rf_rd_addr = A_ACC;
            bus.rf_rd_data = r_result;
        end else begin
            bus.rf_we      = 1'b0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.stall_cnt = r_stall;

endmodule

// File: tb/tb_dsp_rf_sequencer.sv
// Directed bench for dsp_rf_sequencer with a register-file model and a write scoreboard.
// Every write seen on the port is popped from the queue of expected writes.
module tb_dsp_rf_sequencer;
    import dsp_rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        sampled = 1'b0;
    logic [36:0] sb [$];
    logic [31:0] rf [0:18];

    dsp_rf_sequencer_if #(.CNT_W(8)) bus ();

    dsp_rf_sequencer #(
        .SRC_A (16),
        .SRC_B (17),
        .ACC   (18),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.r16_in = rf[16];
    assign bus.r17_in = rf[17];
    assign bus.r18_in = rf[18];

    // Register file model fed by the single write port.
    always @(posedge clk) begin
        if (bus.rf_we && (bus.rf_rd_addr < 5'd19)) rf[bus.rf_rd_addr] <= bus.rf_rd_data;
    end

    function automatic logic [31:0] mac(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return c + (a * b);
    endfunction

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        sampled = 1'b1;
        if (bus.rf_we) begin
            if (sb.size() == 0) chk("spurious_we", {36'd0, bus.rf_we}, 37'd0);
            else chk("rf_write", {bus.rf_rd_addr, bus.rf_rd_data}, sb.pop_front());
        end
    endtask

    task automatic adv();
        if (!sampled) settle();
        @(posedge clk);
        #1;
        sampled = 1'b0;
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        bus.core_we      = 1'b1;
        bus.core_rd_addr = a;
        bus.core_rd_data = d;
        sb.push_back({a, d});
        settle();
        chk("core_pass_we", {36'd0, bus.rf_we}, 37'd1);
        adv();
        bus.core_we = 1'b0;
    endtask

    task automatic kick(input logic [7:0] n);
        bus.start = 1'b1;
        bus.count = n;
        adv();
        bus.start = 1'b0;
    endtask

    // Cycle-by-cycle checks of a run; cycle 0 is the first cycle after start is sampled.
    task automatic run(input string tag, input int ncyc, input int done_k,
                       input logic [15:0] we_mask, input logic [15:0] start_mask,
                       input int core_k, input logic [4:0] core_a, input logic [31:0] core_d,
                       input logic chk_stall, input logic [15:0] exp_stall);
        for (int k = 0; k < ncyc; k++) begin
            bus.core_we      = (k == core_k);
            bus.core_rd_addr = core_a;
            bus.core_rd_data = core_d;
            bus.start        = start_mask[k];
            bus.count        = 8'd1;
            settle();
            chk({tag, "_we"}, {36'd0, bus.rf_we}, {36'd0, we_mask[k]});
            chk({tag, "_done"}, {36'd0, bus.done}, {36'd0, (k == done_k)});
            chk({tag, "_busy"}, {36'd0, bus.busy}, {36'd0, (k <= done_k)});
            if (chk_stall && (k == done_k)) chk({tag, "_stall"}, {21'd0, bus.stall_cnt}, {21'd0, exp_stall});
            adv();
        end
        bus.core_we = 1'b0;
        bus.start   = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.count = 8'd0;
        bus.core_we = 1'b0;
        bus.core_rd_addr = 5'd0;
        bus.core_rd_data = 32'd0;
        adv();
        adv();
        settle();
        chk("rst_busy", {36'd0, bus.busy}, 37'd0);
        chk("rst_done", {36'd0, bus.done}, 37'd0);
        chk("rst_stall", {21'd0, bus.stall_cnt}, 37'd0);
        chk("rst_we", {36'd0, bus.rf_we}, 37'd0);
        adv();
        set_reg(5'd0, 32'h0000_0055);
        rst_n = 1'b1;
        adv();

        // Single uncontended iteration
        set_reg(5'd16, 32'd3);
        set_reg(5'd17, 32'd5);
        set_reg(5'd18, 32'd7);
        sb.push_back({5'd18, mac(32'd3, 32'd5, 32'd7)});
        kick(8'd1);
        run("single", 4, 2, 16'h0002, 16'h0000, -1, 5'd0, 32'd0, 1'b1, 16'd0);

        // Non-hazard contention in the first WRITE cycle
        set_reg(5'd16, 32'd2);
        set_reg(5'd17, 32'd4);
        set_reg(5'd18, 32'd0);
        sb.push_back({5'd5, 32'h0000_ABCD});
        sb.push_back({5'd18, mac(32'd2, 32'd4, 32'd0)});
        sb.push_back({5'd18, mac(32'd2, 32'd4, 32'd8)});
        sb.push_back({5'd18, mac(32'd2, 32'd4, 32'd16)});
        kick(8'd3);
        run("contend", 9, 7, 16'h0056, 16'h0000, 1, 5'd5, 32'h0000_ABCD, 1'b1, 16'd1);
        chk("contend_acc", {5'd0, rf[18]}, 37'd24);

        // Hazard: core writes r17 during WRITE, forcing a recompute
        set_reg(5'd16, 32'd2);
        set_reg(5'd17, 32'd3);
        set_reg(5'd18, 32'd1);
        sb.push_back({5'd17, 32'd10});
        sb.push_back({5'd18, mac(32'd2, 32'd10, 32'd1)});
        kick(8'd1);
        run("hazard", 6, 4, 16'h000A, 16'h0000, 1, 5'd17, 32'd10, 1'b1, 16'd1);

        // Zero count: done immediately, no block write
        kick(8'd0);
        run("zero", 2, 0, 16'h0000, 16'h0000, -1, 5'd0, 32'd0, 1'b0, 16'd0);

        // start during CALC and during DONE are both ignored
        sb.push_back({5'd3, 32'h0000_0033});
        sb.push_back({5'd18, mac(32'd2, 32'd10, 32'd21)});
        sb.push_back({5'd18, mac(32'd2, 32'd10, 32'd41)});
        kick(8'd2);
        run("ignore", 8, 5, 16'h0016, 16'h0028, 1, 5'd3, 32'h0000_0033, 1'b1, 16'd1);
        chk("ignore_acc", {5'd0, rf[18]}, 37'd61);

        // Wrap-around of the accumulate
        set_reg(5'd16, 32'hFFFF_FFFF);
        set_reg(5'd17, 32'd2);
        set_reg(5'd18, 32'd1);
        sb.push_back({5'd18, 32'hFFFF_FFFF});
        kick(8'd1);
        run("wrap", 4, 2, 16'h0002, 16'h0000, -1, 5'd0, 32'd0, 1'b1, 16'd0);

        // Reset during cycle 2 of a four-iteration run
        set_reg(5'd16, 32'd1);
        set_reg(5'd17, 32'd1);
        set_reg(5'd18, 32'd0);
        sb.push_back({5'd18, mac(32'd1, 32'd1, 32'd0)});
        kick(8'd4);
        settle();
        chk("mid_busy0", {36'd0, bus.busy}, 37'd1);
        adv();
        adv();
        rst_n = 1'b0;
        settle();
        chk("mid_we2", {36'd0, bus.rf_we}, 37'd0);
        adv();
        rst_n = 1'b1;
        settle();
        chk("mid_rst_busy", {36'd0, bus.busy}, 37'd0);
        chk("mid_rst_done", {36'd0, bus.done}, 37'd0);
        chk("mid_rst_stall", {21'd0, bus.stall_cnt}, 37'd0);
        chk("mid_rst_we", {36'd0, bus.rf_we}, 37'd0);
        adv();
        sb.push_back({5'd18, mac(32'd1, 32'd1, 32'd1)});
        kick(8'd1);
        run("post_rst", 4, 2, 16'h0002, 16'h0000, -1, 5'd0, 32'd0, 1'b1, 16'd0);

        chk("sb_drained", 37'(sb.size()), 37'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
